alu_sequencer: RTL and testbench

Sequencer for the shared 4-bit signed add/sub datapath, which is the operand prefix stage feeding the ripple add/sub with overflow. It collects operand A, operand B and the op code from the board switches with one "enter" button. It then drives the datapath for one execute cycle and holds the result and overflow for the 7-segment display stage. Results can be chained back in as the next operand A, and an optional multi-cycle multiply reuses the same adder.

---
 rtl/alu_sequencer_if.sv | 51 +++++
 rtl/alu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
//   Bundles the switch/button inputs, the shared add/sub datapath connection
//   and the display outputs of the ALU sequencer.
//
//   Signals:
//     din      4  switch operand value (two's complement)
//     op_in    3  switch op code
//     enter    1  debounced enter button level
//     clear    1  synchronous abort back to operand-A entry
//     mul_req  1  multiply select, sampled together with the op code
//     dp_a     4  datapath operand A          (sequencer -> datapath)
//     dp_b     4  datapath operand B          (sequencer -> datapath)
//     dp_op    3  datapath op code            (sequencer -> datapath)
//     dp_r     4  datapath result             (datapath -> sequencer)
//     dp_ovf   1  datapath overflow           (datapath -> sequencer)
//     result   4  latched result for the display
//     ovf      1  latched overflow for the display
//     busy     1  execute/multiply in progress
//     stage    2  entry stage shown to the user
//
//   Modports:
//     slave  - the sequencer itself
//     master - the environment (switches, datapath and display)
// -----------------------------------------------------------------------------
interface alu_sequencer_if;
    logic [3:0] din;
    logic [2:0] op_in;
    logic       enter;
    logic       clear;
    logic       mul_req;
    logic [3:0] dp_a;
    logic [3:0] dp_b;
    logic [2:0] dp_op;
    logic [3:0] dp_r;
    logic       dp_ovf;
    logic [3:0] result;
    logic       ovf;
    logic       busy;
    logic [1:0] stage;

    modport slave (
        input  din, op_in, enter, clear, mul_req, dp_r, dp_ovf,
        output dp_a, dp_b, dp_op, result, ovf, busy, stage
    );

    modport master (
        output din, op_in, enter, clear, mul_req, dp_r, dp_ovf,
        input  dp_a, dp_b, dp_op, result, ovf, busy, stage
    );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Collects operand A, operand B and the op code from the switches using a
//   single enter button, drives the shared 4-bit signed add/sub datapath for
//   one execute cycle and holds result/overflow for the display. A finished
//   result can be chained back in as the next operand A.
//
//   Optional feature (macro SEQ_MUL_EN): signed 4x4 multiply, truncated to
//   4 bits, built from repeated additions on the same datapath followed by an
//   optional negation. Without the macro mul_req is ignored.
//
//   Parameters:
//     CHAIN_EN  1: enter while showing a result loads it as A, waits for B
//               0: enter while showing a result restarts at A entry
//
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  alu_sequencer_if.slave (switches, datapath, display signals)
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_A        = 3'd0,
        S_B        = 3'd1,
        S_OP       = 3'd2,
        S_EXEC     = 3'd3,
        S_SHOW     = 3'd4
`ifdef SEQ_MUL_EN
        ,
        S_MUL_INIT = 3'd5,
        S_MUL_ADD  = 3'd6,
        S_MUL_NEG  = 3'd7
`endif
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       enter_q;
    logic       enter_evt;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [2:0] op_reg;
    logic [3:0] result_q;
    logic       ovf_q;

`ifdef SEQ_MUL_EN
    logic [3:0] acc;
    logic [3:0] cnt;     // remaining additions, 0..8
    logic       neg;     // B was negative: negate the accumulated product
    logic [3:0] b_mag;   // |B|; -8 maps to 4'd8 when read as unsigned

    assign b_mag = b_reg[3] ? (4'd0 - b_reg) : b_reg;
`else
    logic unused_mul;
    assign unused_mul = bus.mul_req;
`endif

    // Rising edge of the already-debounced level: a held button is one event.
    assign enter_evt = bus.enter & ~enter_q;

    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_A;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        bus.dp_a   = 4'd0;
        bus.dp_b   = 4'd0;
        bus.dp_op  = 3'd0;
        bus.busy   = 1'b0;
        bus.stage  = 2'b11;

        case (state)
            S_A: begin
                bus.stage = 2'b00;
                if (enter_evt) state_next = S_B;
            end
            S_B: begin
                bus.stage = 2'b01;
                if (enter_evt) state_next = S_OP;
            end
            S_OP: begin
                bus.stage = 2'b10;
                if (enter_evt) begin
`ifdef SEQ_MUL_EN
                    state_next = bus.mul_req ? S_MUL_INIT : S_EXEC;
`else
                    state_next = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                bus.busy   = 1'b1;
                bus.dp_a   = a_reg;
                bus.dp_b   = b_reg;
                bus.dp_op  = op_reg;
                state_next = S_SHOW;
            end
            S_SHOW: begin
                if (enter_evt) state_next = CHAIN_EN ? S_B : S_A;
            end
`ifdef SEQ_MUL_EN
            S_MUL_INIT: begin
                bus.busy   = 1'b1;
                // A zero multiplier needs no additions: product is 0 at once.
                state_next = (b_mag == 4'd0) ? S_SHOW : S_MUL_ADD;
            end
            S_MUL_ADD: begin
                bus.busy  = 1'b1;
                bus.dp_a  = acc;
                bus.dp_b  = a_reg;
                bus.dp_op = 3'b000;
                // The last addition decides the exit, saving a separate
                // zero-check cycle.
                if (cnt == 4'd1) state_next = neg ? S_MUL_NEG : S_SHOW;
            end
            S_MUL_NEG: begin
                bus.busy   = 1'b1;
                bus.dp_a   = 4'd0;
                bus.dp_b   = acc;
                bus.dp_op  = 3'b001;
                state_next = S_SHOW;
            end
`endif
            default: state_next = S_A;
        endcase

        // Abort wins over any enter event, in every state.
        if (bus.clear) state_next = S_A;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q  <= 1'b0;
            a_reg    <= 4'd0;
            b_reg    <= 4'd0;
            op_reg   <= 3'd0;
            result_q <= 4'd0;
            ovf_q    <= 1'b0;
`ifdef SEQ_MUL_EN
            acc      <= 4'd0;
            cnt      <= 4'd0;
            neg      <= 1'b0;
`endif
        end else begin
            enter_q <= bus.enter;
            // Clear only redirects the FSM; data and display registers keep
            // their contents.
            if (!bus.clear) begin
                case (state)
                    S_A:    if (enter_evt) a_reg  <= bus.din;
                    S_B:    if (enter_evt) b_reg  <= bus.din;
                    S_OP:   if (enter_evt) op_reg <= bus.op_in;
                    S_EXEC: begin
                        result_q <= bus.dp_r;
                        ovf_q    <= bus.dp_ovf;
                    end
                    S_SHOW: begin
                        if (enter_evt && CHAIN_EN) begin
                            a_reg <= result_q;
                            ovf_q <= 1'b0;
                        end
                    end
`ifdef SEQ_MUL_EN
                    S_MUL_INIT: begin
                        acc   <= 4'd0;
                        cnt   <= b_mag;
                        neg   <= b_reg[3];
                        ovf_q <= 1'b0;
                        if (b_mag == 4'd0) result_q <= 4'd0;
                    end
                    S_MUL_ADD: begin
                        acc   <= bus.dp_r;
                        ovf_q <= ovf_q | bus.dp_ovf;
                        cnt   <= cnt - 4'd1;
                        if (cnt == 4'd1 && !neg) result_q <= bus.dp_r;
                    end
                    S_MUL_NEG: begin
                        result_q <= bus.dp_r;
                        ovf_q    <= ovf_q | bus.dp_ovf;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Drives alu_sequencer through its interface, models the external add/sub
//   datapath, and checks stage/busy/result/ovf/dp_* every cycle against an
//   arithmetic model of each operation, plus hand-computed literal results.
//   Follows SEQ_MUL_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

`ifdef SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0] r;
        logic       v;
        int         nb;   // cycles the sequencer stays busy
    } res_t;

    logic clk = 1'b0;
    logic rst;

    alu_sequencer_if sif ();

    alu_sequencer #(.CHAIN_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int busy_cnt = 0;

    logic       chk_en = 1'b0;
    logic       dp_chk = 1'b0;
    logic [1:0] exp_stage  = 2'b00;
    logic       exp_busy   = 1'b0;
    logic [3:0] exp_result = 4'd0;
    logic       exp_ovf    = 1'b0;
    logic [3:0] exp_dp_a   = 4'd0;
    logic [3:0] exp_dp_b   = 4'd0;
    logic [2:0] exp_dp_op  = 3'd0;
    logic [3:0] m_a        = 4'd0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [3:0] wrap4(input int x);
        int m;
        m = ((x % 16) + 16) % 16;
        return 4'(m);
    endfunction

    function automatic int swrap(input int x);
        int m;
        m = ((x % 16) + 16) % 16;
        return (m > 7) ? m - 16 : m;
    endfunction

    // External datapath: {ovf, r}
    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
        int sa, sb, s;
        logic [3:0] r;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        v  = 1'b0;
        case (op)
            3'd0: s = sa + sb;
            3'd1: s = sa - sb;
            3'd6: s = -sa;
            default: s = 0;
        endcase
        case (op)
            3'd0, 3'd1, 3'd6: begin r = wrap4(s); v = (s > 7) || (s < -8); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            default: r = b;
        endcase
        return {v, r};
    endfunction

    // Multiply by |B| repeated additions of A (sticky overflow on any partial
    // sum leaving -8..7), then negation when B < 0.
    function automatic res_t mul_model(input logic [3:0] a, input logic [3:0] b);
        res_t o;
        int av, bv, n;
        av = $signed(a);
        bv = $signed(b);
        n  = (bv < 0) ? -bv : bv;
        o.v = 1'b0;
        for (int k = 1; k <= n; k++)
            if (av * k > 7 || av * k < -8) o.v = 1'b1;
        if (bv < 0 && swrap(av * n) == -8) o.v = 1'b1;
        o.r  = wrap4(av * bv);
        o.nb = (n == 0) ? 1 : 1 + n + ((bv < 0) ? 1 : 0);
        return o;
    endfunction

    always_comb begin
        {sif.dp_ovf, sif.dp_r} = alu(sif.dp_a, sif.dp_b, sif.dp_op);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en && !rst) begin
                if (sif.busy === 1'b1) busy_cnt++;
                check("stage", 8'(sif.stage), 8'(exp_stage));
                check("busy", 8'(sif.busy), 8'(exp_busy));
                check("result", 8'(sif.result), 8'(exp_result));
                if (!exp_busy) begin
                    check("ovf", 8'(sif.ovf), 8'(exp_ovf));
                    check("dp_a_idle", 8'(sif.dp_a), 8'd0);
                    check("dp_b_idle", 8'(sif.dp_b), 8'd0);
                    check("dp_op_idle", 8'(sif.dp_op), 8'd0);
                end
                if (dp_chk) begin
                    check("dp_a_exec", 8'(sif.dp_a), 8'(exp_dp_a));
                    check("dp_b_exec", 8'(sif.dp_b), 8'(exp_dp_b));
                    check("dp_op_exec", 8'(sif.dp_op), 8'(exp_dp_op));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    // Drive inputs at the falling edge, return at the following rising edge.
    task automatic step(input logic en, input logic clr, input logic [3:0] d,
                        input logic [2:0] o, input logic m);
        @(negedge clk);
        sif.enter   = en;
        sif.clear   = clr;
        sif.din     = d;
        sif.op_in   = o;
        sif.mul_req = m;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd4(), 3'd0, 1'b0);
    endtask

    // Clear back to A entry, then enter operand A.
    task automatic new_a(input logic [3:0] a);
        step(1'b0, 1'b1, rnd4(), 3'd0, 1'b0);
        exp_stage = 2'b00;
        step(1'b1, 1'b0, a, 3'd0, 1'b0);
        exp_stage = 2'b01;
        m_a = a;
        step(1'b0, 1'b0, rnd4(), 3'd0, 1'b0);
    endtask

    // From a shown result: chain it in as operand A.
    task automatic chain();
        step(1'b1, 1'b0, rnd4(), 3'd0, 1'b0);
        exp_stage = 2'b01;
        exp_ovf   = 1'b0;
        m_a       = exp_result;
        step(1'b0, 1'b0, rnd4(), 3'd0, 1'b0);
    endtask

    // With operand A entered: enter B, enter op, run to the shown result.
    task automatic run_op(input logic [3:0] b, input logic [2:0] op, input logic m);
        res_t res;
        logic [4:0] dr;
        logic mul_eff;
        step(1'b1, 1'b0, b, 3'd0, 1'b0);
        exp_stage = 2'b10;
        step(1'b0, 1'b0, rnd4(), 3'd0, 1'b0);
        mul_eff = m && MUL_ON;
        if (mul_eff) begin
            res = mul_model(m_a, b);
        end else begin
            dr     = alu(m_a, b, op);
            res.r  = dr[3:0];
            res.v  = dr[4];
            res.nb = 1;
        end
        busy_cnt = 0;
        step(1'b1, 1'b0, rnd4(), op, m);
        exp_stage = 2'b11;
        exp_busy  = 1'b1;
        if (!mul_eff) begin
            dp_chk    = 1'b1;
            exp_dp_a  = m_a;
            exp_dp_b  = b;
            exp_dp_op = op;
        end
        // A fresh enter press mid-multiply must be ignored.
        for (int i = 1; i < res.nb; i++)
            step(i == 2, 1'b0, rnd4(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, rnd4(), 3'd0, 1'b0);
        exp_busy   = 1'b0;
        dp_chk     = 1'b0;
        exp_result = res.r;
        exp_ovf    = res.v;
    endtask

    task automatic set_reset_expect();
        exp_stage  = 2'b00;
        exp_busy   = 1'b0;
        exp_result = 4'd0;
        exp_ovf    = 1'b0;
        dp_chk     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stage"}, 8'(sif.stage), 8'd0);
        check({tag, "_busy"}, 8'(sif.busy), 8'd0);
        check({tag, "_result"}, 8'(sif.result), 8'd0);
        check({tag, "_ovf"}, 8'(sif.ovf), 8'd0);
        check({tag, "_dp_a"}, 8'(sif.dp_a), 8'd0);
        check({tag, "_dp_b"}, 8'(sif.dp_b), 8'd0);
        check({tag, "_dp_op"}, 8'(sif.dp_op), 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst         = 1'b1;
        sif.enter   = 1'b0;
        sif.clear   = 1'b0;
        sif.din     = 4'd0;
        sif.op_in   = 3'd0;
        sif.mul_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        set_reset_expect();
        chk_en = 1'b1;
        idle(2);

        // 3 + 2 = 5, then chain: 5 - 3 = 2
        new_a(4'd3);
        run_op(4'd2, 3'b000, 1'b0);
        idle(1); #1;
        check("lit_3p2_result", 8'(sif.result), 8'h5);
        check("lit_3p2_ovf", 8'(sif.ovf), 8'h0);
        check("lit_3p2_stage", 8'(sif.stage), 8'h3);
        chain();
        #1;
        check("lit_chain_stage", 8'(sif.stage), 8'h1);
        check("lit_chain_ovf", 8'(sif.ovf), 8'h0);
        run_op(4'd3, 3'b001, 1'b0);
        idle(1); #1;
        check("lit_chain_5m3", 8'(sif.result), 8'h2);

        // 7 + 1 overflows
        new_a(4'd7);
        run_op(4'd1, 3'b000, 1'b0);
        idle(1); #1;
        check("lit_7p1_result", 8'(sif.result), 8'h8);
        check("lit_7p1_ovf", 8'(sif.ovf), 8'h1);

        // 2 - 5 = -3
        new_a(4'd2);
        run_op(4'd5, 3'b001, 1'b0);
        idle(1); #1;
        check("lit_2m5_result", 8'(sif.result), 8'hD);
        check("lit_2m5_ovf", 8'(sif.ovf), 8'h0);

        // negate -8 overflows
        new_a(4'h8);
        run_op(4'd0, 3'b110, 1'b0);
        idle(1); #1;
        check("lit_neg8_result", 8'(sif.result), 8'h8);
        check("lit_neg8_ovf", 8'(sif.ovf), 8'h1);

        // Held enter in A entry: exactly one event
        step(1'b0, 1'b1, 4'd0, 3'd0, 1'b0);
        exp_stage = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 4'd6, 3'd0, 1'b0);
            if (i == 0) begin
                exp_stage = 2'b01;
                m_a = 4'd6;
            end
        end
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        #1;
        check("lit_hold_stage", 8'(sif.stage), 8'h1);
        step(1'b1, 1'b0, 4'd1, 3'd0, 1'b0);
        exp_stage = 2'b10;
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        // Clear together with an enter event in op entry: clear wins
        step(1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
        exp_stage = 2'b00;
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        #1;
        check("lit_clear_stage", 8'(sif.stage), 8'h0);
        check("lit_clear_result", 8'(sif.result), 8'h8);

        // mul_req: multiply when enabled, plain add/sub otherwise
        new_a(4'd3);
        run_op(4'hE, 3'b000, 1'b1);
        idle(1); #1;
`ifdef SEQ_MUL_EN
        check("lit_3xm2_result", 8'(sif.result), 8'hA);
        check("lit_3xm2_ovf", 8'(sif.ovf), 8'h0);
        check("lit_3xm2_busy", 8'(busy_cnt), 8'd4);
        new_a(4'h8);
        run_op(4'hF, 3'b000, 1'b1);
        idle(1); #1;
        check("lit_m8xm1_result", 8'(sif.result), 8'h8);
        check("lit_m8xm1_ovf", 8'(sif.ovf), 8'h1);
        new_a(4'd5);
        run_op(4'd0, 3'b000, 1'b1);
        idle(1); #1;
        check("lit_5x0_result", 8'(sif.result), 8'h0);
        check("lit_5x0_busy", 8'(busy_cnt), 8'd1);
`else
        check("lit_mulign_result", 8'(sif.result), 8'h1);
        check("lit_mulign_busy", 8'(busy_cnt), 8'd1);
`endif

        // Asynchronous reset in the middle of an operation
        new_a(4'd5);
        step(1'b1, 1'b0, 4'h8, 3'd0, 1'b0);
        exp_stage = 2'b10;
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 3'd0, 1'b1);
        exp_stage = 2'b11;
        exp_busy  = 1'b1;
        if (!MUL_ON) begin
            dp_chk    = 1'b1;
            exp_dp_a  = 4'd5;
            exp_dp_b  = 4'h8;
            exp_dp_op = 3'd0;
        end
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        if (!MUL_ON) begin
            exp_busy   = 1'b0;
            dp_chk     = 1'b0;
            exp_result = 4'hD;
            exp_ovf    = 1'b0;
        end
        step(1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
        #3;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs("midrst");
        set_reset_expect();
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        new_a(4'd2);
        run_op(4'd3, 3'b000, 1'b1);
        idle(1); #1;
`ifdef SEQ_MUL_EN
        check("lit_after_rst", 8'(sif.result), 8'h6);
`else
        check("lit_after_rst", 8'(sif.result), 8'h5);
`endif

        // Randomized operations, chained or fresh
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1) chain();
            else new_a(rnd4());
            run_op(rnd4(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
